// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - decode-to-execute handshake, operand and forwarding bundle
interface id_ex_stage_if #(
    parameter int STALL_CNT_W = 16
);
    logic                   in_valid_i;
    logic                   in_ready_o;
    logic [3:0]             aluctl_i;
    logic [4:0]             rs_i;
    logic [4:0]             rt_i;
    logic [4:0]             rd_i;
    logic [31:0]            rs_data_i;
    logic [31:0]            rt_data_i;
    logic [31:0]            imm_i;
    logic                   alusrc_i;
    logic                   regwrite_i;
    logic                   exmem_regwrite_i;
    logic [4:0]             exmem_rd_i;
    logic [31:0]            exmem_data_i;
    logic                   memwb_regwrite_i;
    logic [4:0]             memwb_rd_i;
    logic [31:0]            memwb_data_i;
    logic                   flush_i;
    logic                   out_valid_o;
    logic                   out_ready_i;
    logic [3:0]             aluctl_o;
    logic [31:0]            a_o;
    logic [31:0]            b_o;
    logic [4:0]             rd_o;
    logic                   regwrite_o;
    logic [STALL_CNT_W-1:0] stall_cnt_o;

    modport slave (
        input  in_valid_i, aluctl_i, rs_i, rt_i, rd_i, rs_data_i, rt_data_i, imm_i,
               alusrc_i, regwrite_i, exmem_regwrite_i, exmem_rd_i, exmem_data_i,
               memwb_regwrite_i, memwb_rd_i, memwb_data_i, flush_i, out_ready_i,
        output in_ready_o, out_valid_o, aluctl_o, a_o, b_o, rd_o, regwrite_o, stall_cnt_o
    );

    modport master (
        output in_valid_i, aluctl_i, rs_i, rt_i, rd_i, rs_data_i, rt_data_i, imm_i,
               alusrc_i, regwrite_i, exmem_regwrite_i, exmem_rd_i, exmem_data_i,
               memwb_regwrite_i, memwb_rd_i, memwb_data_i, flush_i, out_ready_i,
        input  in_ready_o, out_valid_o, aluctl_o, a_o, b_o, rd_o, regwrite_o, stall_cnt_o
    );
endinterface

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - one-entry ID/EX pipeline register with operand forwarding
module id_ex_stage #(
    parameter int STALL_CNT_W = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    id_ex_stage_if.slave  bus
);
    logic                   valid_q;
    logic [3:0]             aluctl_q;
    logic [31:0]            a_q;
    logic [31:0]            b_q;
    logic [4:0]             rd_q;
    logic                   regwrite_q;
    logic [4:0]             rs_q;
    logic [4:0]             rt_q;
    logic                   alusrc_q;
    logic [STALL_CNT_W-1:0] stall_cnt_q;
    logic                   ready;
    logic                   capture;
    logic                   stall;

    // Register 0 is hard-wired; the younger producer (EX/MEM) wins over MEM/WB.
    function automatic logic [31:0] resolve(input logic [4:0] idx, input logic [31:0] rf_data);
        logic [31:0] r;
        if (idx == 5'd0)
            r = 32'd0;
        else if (bus.exmem_regwrite_i && bus.exmem_rd_i == idx)
            r = bus.exmem_data_i;
        else if (bus.memwb_regwrite_i && bus.memwb_rd_i == idx)
            r = bus.memwb_data_i;
        else
            r = rf_data;
        return r;
    endfunction

    always_comb begin
        ready   = !valid_q || bus.out_ready_i;
        capture = bus.in_valid_i && ready && !bus.flush_i;
        stall   = valid_q && !bus.out_ready_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q    <= 1'b0;
            aluctl_q   <= 4'd0;
            a_q        <= 32'd0;
            b_q        <= 32'd0;
            rd_q       <= 5'd0;
            regwrite_q <= 1'b0;
            rs_q       <= 5'd0;
            rt_q       <= 5'd0;
            alusrc_q   <= 1'b0;
        end else if (bus.flush_i) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
        end else if (capture) begin
            valid_q    <= 1'b1;
            aluctl_q   <= bus.aluctl_i;
            a_q        <= resolve(bus.rs_i, bus.rs_data_i);
            b_q        <= bus.alusrc_i ? bus.imm_i : resolve(bus.rt_i, bus.rt_data_i);
            rd_q       <= bus.rd_i;
            regwrite_q <= bus.regwrite_i;
            rs_q       <= bus.rs_i;
            rt_q       <= bus.rt_i;
            alusrc_q   <= bus.alusrc_i;
        end else if (valid_q && bus.out_ready_i) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
        end else if (valid_q) begin
            // Held beat keeps snooping producers that retire while we are stalled.
            a_q <= resolve(rs_q, a_q);
            if (!alusrc_q)
                b_q <= resolve(rt_q, b_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            stall_cnt_q <= '0;
        else if (stall && !(&stall_cnt_q))
            stall_cnt_q <= stall_cnt_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end

    assign bus.in_ready_o  = ready;
    assign bus.out_valid_o = valid_q;
    assign bus.aluctl_o    = aluctl_q;
    assign bus.a_o         = a_q;
    assign bus.b_o         = b_q;
    assign bus.rd_o        = rd_q;
    assign bus.regwrite_o  = regwrite_q;
    assign bus.stall_cnt_o = stall_cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - randomized and directed bench for id_ex_stage against a beat-level model
module tb_id_ex_stage;
    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    id_ex_stage_if                    ifa ();
    id_ex_stage_if #(.STALL_CNT_W(2)) ifb ();

    id_ex_stage                    dut     (.clk_i(clk), .rst_i(rst), .bus(ifa));
    id_ex_stage #(.STALL_CNT_W(2)) dut_sat (.clk_i(clk), .rst_i(rst), .bus(ifb));

    always_comb begin
        ifb.in_valid_i       = ifa.in_valid_i;
        ifb.aluctl_i         = ifa.aluctl_i;
        ifb.rs_i             = ifa.rs_i;
        ifb.rt_i             = ifa.rt_i;
        ifb.rd_i             = ifa.rd_i;
        ifb.rs_data_i        = ifa.rs_data_i;
        ifb.rt_data_i        = ifa.rt_data_i;
        ifb.imm_i            = ifa.imm_i;
        ifb.alusrc_i         = ifa.alusrc_i;
        ifb.regwrite_i       = ifa.regwrite_i;
        ifb.exmem_regwrite_i = ifa.exmem_regwrite_i;
        ifb.exmem_rd_i       = ifa.exmem_rd_i;
        ifb.exmem_data_i     = ifa.exmem_data_i;
        ifb.memwb_regwrite_i = ifa.memwb_regwrite_i;
        ifb.memwb_rd_i       = ifa.memwb_rd_i;
        ifb.memwb_data_i     = ifa.memwb_data_i;
        ifb.flush_i          = ifa.flush_i;
        ifb.out_ready_i      = ifa.out_ready_i;
    end

    // Beat-level model: the entry currently presented to the ALU, plus bookkeeping.
    typedef struct {
        bit        valid;
        bit [3:0]  aluctl;
        bit [31:0] a;
        bit [31:0] b;
        bit [4:0]  rd;
        bit        rw;
        bit [4:0]  rs;
        bit [4:0]  rt;
        bit        src;
    } beat_t;

    beat_t m;
    int    cnt16;
    int    cnt2;

    function automatic bit [31:0] fwd(bit [4:0] idx, bit [31:0] base);
        if (idx == 0) return 0;
        if (ifa.exmem_regwrite_i && ifa.exmem_rd_i == idx) return ifa.exmem_data_i;
        if (ifa.memwb_regwrite_i && ifa.memwb_rd_i == idx) return ifa.memwb_data_i;
        return base;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        bit accepts = !m.valid || ifa.out_ready_i;
        bit stalled = m.valid && !ifa.out_ready_i;
        if (rst) begin
            m = '{default: 0};
            cnt16 = 0;
            cnt2  = 0;
            return;
        end
        if (stalled) begin
            if (cnt16 < 65535) cnt16++;
            if (cnt2 < 3) cnt2++;
        end
        if (ifa.flush_i) begin
            m.valid = 0;
            m.rw    = 0;
        end else if (ifa.in_valid_i && accepts) begin
            m.valid  = 1;
            m.aluctl = ifa.aluctl_i;
            m.a      = fwd(ifa.rs_i, ifa.rs_data_i);
            m.b      = ifa.alusrc_i ? ifa.imm_i : fwd(ifa.rt_i, ifa.rt_data_i);
            m.rd     = ifa.rd_i;
            m.rw     = ifa.regwrite_i;
            m.rs     = ifa.rs_i;
            m.rt     = ifa.rt_i;
            m.src    = ifa.alusrc_i;
        end else if (m.valid && ifa.out_ready_i) begin
            m.valid = 0;
            m.rw    = 0;
        end else if (m.valid) begin
            m.a = fwd(m.rs, m.a);
            if (!m.src) m.b = fwd(m.rt, m.b);
        end
    endtask

    task automatic step(string tag);
        #1;
        chk({tag, ":in_ready"}, 32'(ifa.in_ready_o), 32'(!m.valid || ifa.out_ready_i));
        model_update();
        @(posedge clk);
        #1;
        chk({tag, ":valid"},    32'(ifa.out_valid_o), 32'(m.valid));
        chk({tag, ":a"},        ifa.a_o, m.a);
        chk({tag, ":b"},        ifa.b_o, m.b);
        chk({tag, ":aluctl"},   32'(ifa.aluctl_o), 32'(m.aluctl));
        chk({tag, ":rd"},       32'(ifa.rd_o), 32'(m.rd));
        chk({tag, ":regwrite"}, 32'(ifa.regwrite_o), 32'(m.rw));
        chk({tag, ":stall16"},  32'(ifa.stall_cnt_o), 32'(cnt16));
        chk({tag, ":stall2"},   32'(ifb.stall_cnt_o), 32'(cnt2));
    endtask

    task automatic quiet();
        ifa.in_valid_i = 0; ifa.aluctl_i = 0; ifa.rs_i = 0; ifa.rt_i = 0; ifa.rd_i = 0;
        ifa.rs_data_i = 0; ifa.rt_data_i = 0; ifa.imm_i = 0; ifa.alusrc_i = 0;
        ifa.regwrite_i = 0; ifa.exmem_regwrite_i = 0; ifa.exmem_rd_i = 0;
        ifa.exmem_data_i = 0; ifa.memwb_regwrite_i = 0; ifa.memwb_rd_i = 0;
        ifa.memwb_data_i = 0; ifa.flush_i = 0; ifa.out_ready_i = 1;
    endtask

    task automatic beat(bit [4:0] rs, bit [4:0] rt, bit [31:0] rsd, bit [31:0] rtd,
                        bit [31:0] imm, bit src, bit [3:0] alu);
        ifa.in_valid_i = 1; ifa.rs_i = rs; ifa.rt_i = rt; ifa.rs_data_i = rsd;
        ifa.rt_data_i = rtd; ifa.imm_i = imm; ifa.alusrc_i = src; ifa.aluctl_i = alu;
        ifa.rd_i = 5'd9; ifa.regwrite_i = 1;
    endtask

    initial begin
        m = '{default: 0};
        cnt16 = 0;
        cnt2  = 0;
        quiet();
        rst = 1;
        beat(5'd1, 5'd2, 32'h55, 32'h66, 32'h0, 1'b0, 4'd7);
        step("reset0");
        step("reset1");
        rst = 0;
        quiet();
        step("post_reset");
        chk("reset:valid_lit", 32'(ifa.out_valid_o), 32'd0);

        beat(5'd1, 5'd2, 32'd5, 32'd7, 32'd0, 1'b0, 4'd2);
        step("basic");
        chk("basic:a_lit", ifa.a_o, 32'd5);
        chk("basic:b_lit", ifa.b_o, 32'd7);

        beat(5'd3, 5'd3, 32'h99, 32'h98, 32'd0, 1'b0, 4'd1);
        ifa.exmem_regwrite_i = 1; ifa.exmem_rd_i = 5'd3; ifa.exmem_data_i = 32'h11;
        ifa.memwb_regwrite_i = 1; ifa.memwb_rd_i = 5'd3; ifa.memwb_data_i = 32'h22;
        step("fwd_prio");
        chk("fwd_prio:a_lit", ifa.a_o, 32'h11);
        chk("fwd_prio:b_lit", ifa.b_o, 32'h11);
        ifa.rs_i = 5'd0;
        step("fwd_zero");
        chk("fwd_zero:a_lit", ifa.a_o, 32'h0);

        quiet();
        beat(5'd4, 5'd5, 32'd9, 32'd10, 32'd0, 1'b0, 4'd3);
        step("stall_load");
        ifa.out_ready_i = 0;
        step("stall_c1");
        ifa.memwb_regwrite_i = 1; ifa.memwb_rd_i = 5'd4; ifa.memwb_data_i = 32'hABCD;
        step("stall_c2");
        ifa.memwb_regwrite_i = 0;
        step("stall_c3");
        chk("stall:a_lit", ifa.a_o, 32'hABCD);
        chk("stall:cnt_lit", 32'(ifa.stall_cnt_o), 32'd3);

        quiet();
        for (int i = 1; i <= 4; i++) begin
            beat(5'd1, 5'd2, 32'd0, 32'd0, 32'(i), 1'b1, 4'd4);
            step("b2b");
            chk("b2b:b_lit", ifa.b_o, 32'(i));
            chk("b2b:valid_lit", 32'(ifa.out_valid_o), 32'd1);
        end

        ifa.out_ready_i = 0;
        beat(5'd6, 5'd7, 32'h1234, 32'h5678, 32'd0, 1'b0, 4'd5);
        ifa.flush_i = 1;
        step("flush");
        chk("flush:valid_lit", 32'(ifa.out_valid_o), 32'd0);
        chk("flush:rw_lit", 32'(ifa.regwrite_o), 32'd0);
        ifa.flush_i = 0;
        ifa.in_valid_i = 0;
        step("flush_after");

        for (int n = 0; n < 400; n++) begin
            rst                  = ($urandom_range(0, 63) == 0);
            ifa.in_valid_i       = $urandom_range(0, 3) != 0;
            ifa.out_ready_i      = $urandom_range(0, 2) != 0;
            ifa.flush_i          = ($urandom_range(0, 15) == 0);
            ifa.aluctl_i         = 4'($urandom);
            ifa.rs_i             = 5'($urandom_range(0, 7));
            ifa.rt_i             = 5'($urandom_range(0, 7));
            ifa.rd_i             = 5'($urandom);
            ifa.rs_data_i        = $urandom;
            ifa.rt_data_i        = $urandom;
            ifa.imm_i            = $urandom;
            ifa.alusrc_i         = 1'($urandom);
            ifa.regwrite_i       = 1'($urandom);
            ifa.exmem_regwrite_i = 1'($urandom);
            ifa.exmem_rd_i       = 5'($urandom_range(0, 7));
            ifa.exmem_data_i     = $urandom;
            ifa.memwb_regwrite_i = 1'($urandom);
            ifa.memwb_rd_i       = 5'($urandom_range(0, 7));
            ifa.memwb_data_i     = $urandom;
            step("rand");
        end

        rst = 1;
        quiet();
        step("sat_reset");
        rst = 0;
        beat(5'd2, 5'd3, 32'h7, 32'h8, 32'd0, 1'b0, 4'd6);
        step("sat_load");
        ifa.out_ready_i = 0;
        for (int i = 0; i < 6; i++) step("sat_hold");
        chk("sat:cnt2_lit", 32'(ifb.stall_cnt_o), 32'd3);
        chk("sat:cnt16_lit", 32'(ifa.stall_cnt_o), 32'd6);
        rst = 1;
        step("mid_stall_reset");
        chk("rst:valid_lit", 32'(ifa.out_valid_o), 32'd0);
        chk("rst:a_lit", ifa.a_o, 32'd0);
        chk("rst:cnt_lit", 32'(ifb.stall_cnt_o), 32'd0);
        rst = 0;
        ifa.in_valid_i = 0;
        step("post_rst_ready");
        chk("rst:ready_lit", 32'(ifa.in_ready_o), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
